// File: rtl/pipeline_pkg.sv
// Shared constants, instruction field positions and issuer state type for the
// 5-stage Pipeline core front end.
package pipeline_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP = 32'h0;

    localparam int unsigned OPC_MSB = 31;
    localparam int unsigned OPC_LSB = 26;
    localparam int unsigned RD_MSB  = 25;
    localparam int unsigned RD_LSB  = 21;
    localparam int unsigned RS_MSB  = 20;
    localparam int unsigned RS_LSB  = 16;
    localparam int unsigned RT_MSB  = 15;
    localparam int unsigned RT_LSB  = 11;
    localparam int unsigned IMM_MSB = 15;
    localparam int unsigned IMM_LSB = 0;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } issue_state_e;

    function automatic logic [OPC_MSB-OPC_LSB:0] instr_opcode(input logic [INSTR_W-1:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/issue_tag_delay.sv
// Fixed-depth shift line of {valid, index} tags that tracks issued instructions
// through the core so each result can be matched to its program index.
module issue_tag_delay
    import pipeline_pkg::*;
#(
    parameter int unsigned Depth = 3,
    parameter int unsigned IdxW  = 3
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    input  logic [IdxW-1:0] index_i,
    output logic            valid_o,
    output logic [IdxW-1:0] index_o,
    output logic            empty_o
);

    logic [Depth-1:0] valid_q;
    logic [IdxW-1:0]  index_q [Depth];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= '0;
            for (int i = 0; i < int'(Depth); i++) begin
                index_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= valid_i;
            index_q[0] <= index_i;
            for (int i = 1; i < int'(Depth); i++) begin
                valid_q[i] <= valid_q[i-1];
                index_q[i] <= index_q[i-1];
            end
        end
    end

    assign valid_o = valid_q[Depth-1];
    assign index_o = index_q[Depth-1];
    assign empty_o = ~|valid_q;

endmodule

// File: rtl/instr_issuer.sv
// Buffers a short program, presents each word to the core for ISSUE_GAP cycles and
// captures the core result PIPE_LAT cycles later, tagged with its program index.
module instr_issuer
    import pipeline_pkg::*;
#(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned ISSUE_GAP = 3,
    parameter int unsigned PIPE_LAT  = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_valid,
    input  logic [INSTR_W-1:0]       load_instr,
    output logic                     load_ready,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [INSTR_W-1:0]       instr_out,
    input  logic [INSTR_W-1:0]       pipe_result,
    output logic                     res_valid,
    output logic [INSTR_W-1:0]       res_data,
    output logic [$clog2(DEPTH)-1:0] res_index
);

    localparam int unsigned IdxW = $clog2(DEPTH);
    localparam int unsigned CntW = IdxW + 1;
    localparam int unsigned GapW = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;

    issue_state_e state_q, state_d;

    logic [INSTR_W-1:0] buf_q [DEPTH];
    logic [IdxW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [IdxW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]    count_q, count_d;
    logic [GapW-1:0]    gap_q, gap_d;
    logic               first_q, first_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               load_ready_q, load_ready_d;
    logic               res_valid_q;
    logic [INSTR_W-1:0] res_data_q;
    logic [IdxW-1:0]    res_index_q;

    logic            load_acc;
    logic            start_go;
    logic            gap_end;
    logic            last_entry;
    logic [IdxW-1:0] rd_next;
    logic            tag_valid;
    logic [IdxW-1:0] tag_index;
    logic            tag_empty;

    assign load_acc   = load_valid && load_ready_q && (state_q == IDLE);
    // A word accepted on the start edge still belongs to the program.
    assign start_go   = start && (state_q == IDLE) && ((count_q != '0) || load_acc);
    assign gap_end    = (gap_q == GapW'(ISSUE_GAP - 1));
    assign last_entry = (({1'b0, rd_ptr_q} + CntW'(1)) == count_q);
    assign rd_next    = rd_ptr_q + IdxW'(1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_go) state_d = ISSUE;
            ISSUE:   if (gap_end && last_entry) state_d = DRAIN;
            DRAIN:   if (tag_empty) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == ISSUE) || (state_q == DRAIN);
        done = (state_q == DONE);
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        gap_d    = gap_q;
        first_d  = 1'b0;
        instr_d  = instr_q;
        if (load_acc) begin
            wr_ptr_d = wr_ptr_q + IdxW'(1);
            count_d  = count_q + CntW'(1);
        end
        unique case (state_q)
            IDLE: begin
                if (start_go) begin
                    rd_ptr_d = '0;
                    gap_d    = '0;
                    first_d  = 1'b1;
                    instr_d  = (count_q == '0) ? load_instr : buf_q[0];
                end
            end
            ISSUE: begin
                if (gap_end) begin
                    gap_d = '0;
                    if (last_entry) begin
                        instr_d = NOP;
                    end else begin
                        rd_ptr_d = rd_next;
                        instr_d  = buf_q[rd_next];
                        first_d  = 1'b1;
                    end
                end else begin
                    gap_d = gap_q + GapW'(1);
                end
            end
            DRAIN: instr_d = NOP;
            DONE: begin
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                count_d  = '0;
            end
            default: ;
        endcase
        load_ready_d = (state_d == IDLE) && (count_d < CntW'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (load_acc) begin
            buf_q[wr_ptr_q] <= load_instr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            gap_q        <= '0;
            first_q      <= 1'b0;
            instr_q      <= NOP;
            load_ready_q <= 1'b0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_index_q  <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            gap_q        <= gap_d;
            first_q      <= first_d;
            instr_q      <= instr_d;
            load_ready_q <= load_ready_d;
            res_valid_q  <= tag_valid;
            if (tag_valid) begin
                res_data_q  <= pipe_result;
                res_index_q <= tag_index;
            end
        end
    end

    // Tag enters on the first cycle an instruction is on the bus.
    issue_tag_delay #(
        .Depth (PIPE_LAT),
        .IdxW  (IdxW)
    ) u_tag_delay (
        .clk_i   (clk),
        .rst_ni  (rst),
        .valid_i (first_q),
        .index_i (rd_ptr_q),
        .valid_o (tag_valid),
        .index_o (tag_index),
        .empty_o (tag_empty)
    );

    assign load_ready = load_ready_q;
    assign instr_out  = instr_q;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign res_index  = res_index_q;

endmodule
